// File: rtl/core_pip_fetch.sv
// core_pip_fetch: KayRV32 fetch stage; one outstanding imem request, one-entry skid under
// decode stall, redirect flush with in-flight response kill, misaligned-target fault.
module core_pip_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_ISTR     = 32'h0000_0013
) (
  input  logic        i_Clk,
  input  logic        i_Rstn,
  input  logic        i_StallEn,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  output logic        o_MemReq,
  output logic [31:0] o_MemAddr,
  input  logic        i_MemAck,
  input  logic        i_MemValid,
  input  logic [31:0] i_MemData,
  output logic [31:0] o_PC,
  output logic [31:0] o_Istr,
  output logic        o_Valid,
  output logic        o_Event
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SKID, S_FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, istr_q, istr_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_istr_q, skid_istr_d;
  logic        valid_q, valid_d, event_q, event_d, kill_q, kill_d, in_flight;
  // a response is still owed by memory after this edge unless it arrives now
  assign in_flight = (state_q == S_REQ && i_MemAck) || ((state_q == S_WAIT || kill_q) && !i_MemValid);
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    istr_d      = istr_q;
    valid_d     = valid_q;
    event_d     = 1'b0;
    kill_d      = kill_q;
    skid_pc_d   = skid_pc_q;
    skid_istr_d = skid_istr_q;
    if (i_Redirect) begin
      fetch_pc_d = i_Target;
      valid_d    = 1'b0;
      istr_d     = NOP_ISTR;
      event_d    = |i_Target[1:0];
      kill_d     = in_flight;
      state_d    = event_d ? S_FAULT : in_flight ? S_WAIT : S_REQ;
    end else begin
      if (!i_StallEn) begin
        valid_d = 1'b0;
        istr_d  = NOP_ISTR;
      end
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  state_d = i_MemAck ? S_WAIT : S_REQ;
        S_WAIT: if (i_MemValid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (i_StallEn) begin
            skid_pc_d   = fetch_pc_q;
            skid_istr_d = i_MemData;
            fetch_pc_d  = fetch_pc_q + 32'd4;
            state_d     = S_SKID;
          end else begin
            pc_d       = fetch_pc_q;
            istr_d     = i_MemData;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_REQ;
          end
        end
        S_SKID: if (!i_StallEn) begin
          pc_d    = skid_pc_q;
          istr_d  = skid_istr_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
        S_FAULT: kill_d = kill_q && !i_MemValid;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rstn)
    if (!i_Rstn) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_VECTOR;
      pc_q        <= RESET_VECTOR;
      istr_q      <= NOP_ISTR;
      valid_q     <= 1'b0;
      event_q     <= 1'b0;
      kill_q      <= 1'b0;
      skid_pc_q   <= RESET_VECTOR;
      skid_istr_q <= NOP_ISTR;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      istr_q      <= istr_d;
      valid_q     <= valid_d;
      event_q     <= event_d;
      kill_q      <= kill_d;
      skid_pc_q   <= skid_pc_d;
      skid_istr_q <= skid_istr_d;
    end
  assign o_MemReq  = state_q == S_REQ;
  assign o_MemAddr = {fetch_pc_q[31:2], 2'b00};
  assign o_PC      = pc_q;
  assign o_Istr    = istr_q;
  assign o_Valid   = valid_q;
  assign o_Event   = event_q;
endmodule

// File: tb/tb_core_pip_fetch.sv
// tb_core_pip_fetch: directed scenarios then randomized traffic against an instruction-stream
// reference (expected PC/request sequences, restarted on redirect) and a latency-driven memory.
module tb_core_pip_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        i_Clk = 1'b0, i_Rstn = 1'b1, i_StallEn = 1'b0, i_Redirect = 1'b0;
  logic        i_MemAck = 1'b0, i_MemValid = 1'b0;
  logic [31:0] i_Target = '0, i_MemData = '0;
  logic        o_MemReq, o_Valid, o_Event;
  logic [31:0] o_MemAddr, o_PC, o_Istr;
  core_pip_fetch dut (
    .i_Clk(i_Clk), .i_Rstn(i_Rstn), .i_StallEn(i_StallEn), .i_Redirect(i_Redirect),
    .i_Target(i_Target), .o_MemReq(o_MemReq), .o_MemAddr(o_MemAddr), .i_MemAck(i_MemAck),
    .i_MemValid(i_MemValid), .i_MemData(i_MemData), .o_PC(o_PC), .o_Istr(o_Istr),
    .o_Valid(o_Valid), .o_Event(o_Event)
  );
  always #5 i_Clk = ~i_Clk;
  int compared = 0, mismatched = 0;
  bit pend, in_fault, xfer, delivered;
  logic [31:0] pend_addr, exp_pc, exp_req;
  int lat, nack, lat_lo, lat_hi, consumed;
  bit p_stall, p_redir, p_req, p_ack, p_valid;
  logic [31:0] p_tgt, p_addr, p_pc, p_istr;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h8 ? 32'h00A0_0093 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    pend = 0; lat = 0; nack = 0; in_fault = 0; exp_pc = 32'h0; exp_req = 32'h0;
    p_stall = 0; p_redir = 0; p_req = 0; p_ack = 0; p_valid = 0;
  endtask
  task automatic step();
    i_MemValid = pend && lat == 0;
    i_MemData  = i_MemValid ? mem(pend_addr) : $urandom;
    i_MemAck   = o_MemReq && nack == 0;
    if (o_MemReq && nack > 0) nack--;
    chk("one_outstanding", 32'(o_MemReq & pend), 32'h0);
    xfer = o_MemReq && i_MemAck;
    if (xfer) begin
      chk("req_addr", o_MemAddr, exp_req);
      exp_req += 32'd4;
    end
    if (o_Valid && !i_StallEn) begin
      chk("pc", o_PC, exp_pc);
      chk("istr", o_Istr, mem(exp_pc));
      exp_pc += 32'd4;
      consumed++;
    end
    if (i_Redirect) begin
      in_fault = i_Target[1:0] != 2'b00;
      if (!in_fault) begin exp_pc = i_Target; exp_req = i_Target; end
    end
    p_stall = i_StallEn; p_redir = i_Redirect; p_tgt = i_Target; p_req = o_MemReq;
    p_ack = i_MemAck; p_addr = o_MemAddr; p_pc = o_PC; p_istr = o_Istr; p_valid = o_Valid;
    delivered = i_MemValid;
    @(posedge i_Clk); #1;
    if (delivered) pend = 0; else if (pend && lat > 0) lat--;
    if (xfer) begin pend = 1; pend_addr = p_addr; lat = $urandom_range(lat_hi, lat_lo); end
    chk("event", 32'(o_Event), 32'(p_redir && p_tgt[1:0] != 2'b00));
    if (!o_Valid) chk("bubble_nop", o_Istr, NOP);
    if (in_fault) chk("fault_noreq", 32'(o_MemReq), 32'h0);
    if (p_req && !p_ack && !p_redir) begin
      chk("addr_hold", o_MemAddr, p_addr);
      chk("req_hold", 32'(o_MemReq), 32'h1);
    end
    if (p_stall && !p_redir) begin
      chk("stall_pc", o_PC, p_pc);
      chk("stall_istr", o_Istr, p_istr);
      chk("stall_valid", 32'(o_Valid), 32'(p_valid));
    end
    if (p_redir) chk("redir_flush", 32'(o_Valid), 32'h0);
  endtask
  initial begin
    int c0;
    logic [31:0] t;
    lat_lo = 0; lat_hi = 0; consumed = 0;
    clear_model();
    #2 i_Rstn = 1'b0;
    #1;
    chk("rst_valid", 32'(o_Valid), 32'h0);
    chk("rst_istr", o_Istr, NOP);
    chk("rst_pc", o_PC, 32'h0);
    chk("rst_req", 32'(o_MemReq), 32'h0);
    chk("rst_event", 32'(o_Event), 32'h0);
    @(posedge i_Clk); #1 i_Rstn = 1'b1;
    // sequential fetch with immediate ack and 1-cycle latency
    step();
    chk("t1_req0", 32'(o_MemReq), 32'h1);
    chk("t1_addr0", o_MemAddr, 32'h0);
    for (int i = 0; i < 20 && !(o_MemReq && o_MemAddr == 32'h4); i++) step();
    chk("t1_addr4", o_MemAddr, 32'h4);
    chk("t1_valid0", 32'(o_Valid), 32'h1);
    chk("t1_pc0", o_PC, 32'h0);
    // ack withheld three cycles on 0x4
    nack = 3;
    repeat (3) step();
    chk("t2_addr_stuck", o_MemAddr, 32'h4);
    chk("t2_no_dup", 32'(o_Valid), 32'h0);
    for (int i = 0; i < 20 && !(o_MemReq && o_MemAddr == 32'h8); i++) step();
    chk("t2_addr8", o_MemAddr, 32'h8);
    // stall across the 0x8 response
    i_StallEn = 1'b1;
    repeat (4) step();
    chk("t3_req_low", 32'(o_MemReq), 32'h0);
    chk("t3_hold_pc", o_PC, 32'h4);
    i_StallEn = 1'b0;
    step();
    chk("t3_pc", o_PC, 32'h8);
    chk("t3_istr", o_Istr, 32'h00A0_0093);
    chk("t3_valid", 32'(o_Valid), 32'h1);
    chk("t3_next_addr", o_MemAddr, 32'hC);
    // redirect while a response is in flight
    lat_lo = 2; lat_hi = 2;
    step();
    i_Redirect = 1'b1; i_Target = 32'h100;
    step();
    i_Redirect = 1'b0;
    chk("t4_valid", 32'(o_Valid), 32'h0);
    chk("t4_istr", o_Istr, NOP);
    for (int i = 0; i < 20 && !o_MemReq; i++) step();
    chk("t4_req_addr", o_MemAddr, 32'h100);
    for (int i = 0; i < 20 && !o_Valid; i++) step();
    chk("t4_pc", o_PC, 32'h100);
    chk("t4_istr_data", o_Istr, mem(32'h100));
    // misaligned redirect parks fetch until an aligned one
    lat_lo = 0; lat_hi = 0;
    i_Redirect = 1'b1; i_Target = 32'h102;
    step();
    i_Redirect = 1'b0;
    chk("t5_event", 32'(o_Event), 32'h1);
    repeat (4) step();
    chk("t5_req_low", 32'(o_MemReq), 32'h0);
    chk("t5_event_off", 32'(o_Event), 32'h0);
    i_Redirect = 1'b1; i_Target = 32'h200;
    step();
    i_Redirect = 1'b0;
    chk("t5_req", 32'(o_MemReq), 32'h1);
    chk("t5_addr", o_MemAddr, 32'h200);
    // async reset in the middle of an outstanding request
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !o_MemReq; i++) step();
    step();
    #2 i_Rstn = 1'b0;
    #1;
    chk("t6_valid", 32'(o_Valid), 32'h0);
    chk("t6_pc", o_PC, 32'h0);
    chk("t6_istr", o_Istr, NOP);
    chk("t6_req", 32'(o_MemReq), 32'h0);
    i_MemValid = 1'b1; i_MemData = 32'hDEAD_BEEF;
    repeat (2) @(posedge i_Clk);
    #1 i_Rstn = 1'b1;
    clear_model();
    step();
    i_MemValid = 1'b0;
    chk("t6_req_after", 32'(o_MemReq), 32'h1);
    chk("t6_addr_after", o_MemAddr, 32'h0);
    // randomized traffic
    lat_lo = 0; lat_hi = 3;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      i_StallEn  = $urandom_range(0, 9) < 3;
      i_Redirect = $urandom_range(0, 49) == 0;
      t = $urandom;
      i_Target = (t & 32'h0000_0FFC) | ($urandom_range(0, 4) == 0 ? 32'h2 : 32'h0);
      if ($urandom_range(0, 9) == 0) i_Target = 32'hFFFF_FFF8;
      if (nack == 0 && $urandom_range(0, 7) == 0) nack = $urandom_range(1, 3);
      step();
    end
    chk("progress", 32'(consumed - c0 > 200), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
